// File: rtl/difftest_commit_unit.sv
// Difftest commit unit: registers up to NCOMMIT writeback commits per cycle,
// keeps a shadow architectural register file, detects the trap instruction,
// counts cycles/instructions and runs a hang watchdog. Freezes on trap/hang
// until reset.

// Per-slot commit register: captures the slot payload when the slot is accepted.
module difftest_commit_slot #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            accept,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    input  logic            rf_we,
    input  logic [4:0]      wnum,
    input  logic [XLEN-1:0] wdata,
    output logic            cmt_valid,
    output logic [XLEN-1:0] cmt_pc,
    output logic [31:0]     cmt_inst,
    output logic            cmt_wen,
    output logic [7:0]      cmt_wdest,
    output logic [XLEN-1:0] cmt_wdata
);
    // valid follows acceptance every cycle; payload only reloads on accept
    always_ff @(posedge clock) begin
        if (reset) begin
            cmt_valid <= 1'b0;
            cmt_pc    <= '0;
            cmt_inst  <= '0;
            cmt_wen   <= 1'b0;
            cmt_wdest <= '0;
            cmt_wdata <= '0;
        end else begin
            cmt_valid <= accept;
            if (accept) begin
                cmt_pc    <= pc;
                cmt_inst  <= inst;
                cmt_wen   <= rf_we & (wnum != 5'd0);
                cmt_wdest <= {3'b000, wnum};
                cmt_wdata <= wdata;
            end
        end
    end
endmodule

module difftest_commit_unit #(
    parameter int         NCOMMIT = 2,
    parameter int         XLEN    = 64,
    parameter int         TIMEOUT = 5000,
    parameter logic [6:0] TRAP_OP = 7'h6b
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NCOMMIT-1:0]      wb_valid,
    input  logic [NCOMMIT*XLEN-1:0] wb_pc,
    input  logic [NCOMMIT*32-1:0]   wb_inst,
    input  logic [NCOMMIT-1:0]      wb_rf_we,
    input  logic [NCOMMIT*5-1:0]    wb_rf_wnum,
    input  logic [NCOMMIT*XLEN-1:0] wb_rf_wdata,
    output logic [NCOMMIT-1:0]      cmt_valid,
    output logic [NCOMMIT*XLEN-1:0] cmt_pc,
    output logic [NCOMMIT*32-1:0]   cmt_inst,
    output logic [NCOMMIT-1:0]      cmt_wen,
    output logic [NCOMMIT*8-1:0]    cmt_wdest,
    output logic [NCOMMIT*XLEN-1:0] cmt_wdata,
    output logic [32*XLEN-1:0]      arch_regs,
    output logic                    trap,
    output logic [7:0]              trap_code,
    output logic [XLEN-1:0]         trap_pc,
    output logic [63:0]             cycle_cnt,
    output logic [63:0]             instr_cnt,
    output logic                    hang
);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(NCOMMIT + 1);

    typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

    state_t state, state_nxt;
    logic   run;

    logic [NCOMMIT-1:0][XLEN-1:0] pc_s, wdata_s, cpc_s, cwdata_s;
    logic [NCOMMIT-1:0][31:0]     inst_s, cinst_s;
    logic [NCOMMIT-1:0][4:0]      wnum_s;
    logic [NCOMMIT-1:0][7:0]      cwdest_s;
    logic [31:0][XLEN-1:0]        rf;

    logic [NCOMMIT-1:0] acc;
    logic               trap_hit;
    logic [XLEN-1:0]    trap_pc_nxt;
    logic [7:0]         trap_code_nxt;
    logic [7:0]         a0_fwd;
    logic               blocked;
    logic [CNT_W-1:0]   n_acc;
    logic [WD_W-1:0]    wd, wd_inc;
    logic               hang_set;

    assign pc_s    = wb_pc;
    assign inst_s  = wb_inst;
    assign wnum_s  = wb_rf_wnum;
    assign wdata_s = wb_rf_wdata;

    // Slot acceptance: in-order walk, everything younger than a trap is dropped.
    // a0 is forwarded through older same-cycle writes so the trap code is exact.
    always_comb begin
        acc           = '0;
        trap_hit      = 1'b0;
        trap_pc_nxt   = '0;
        trap_code_nxt = '0;
        blocked       = 1'b0;
        n_acc         = '0;
        a0_fwd        = rf[10][7:0];
        for (int i = 0; i < NCOMMIT; i++) begin
            if (run && wb_valid[i] && !blocked) begin
                acc[i] = 1'b1;
                n_acc  = n_acc + 1'b1;
                if (inst_s[i][6:0] == TRAP_OP) begin
                    trap_hit      = 1'b1;
                    trap_pc_nxt   = pc_s[i];
                    trap_code_nxt = a0_fwd;
                    blocked       = 1'b1;
                end
                if (wb_rf_we[i] && wnum_s[i] == 5'd10)
                    a0_fwd = wdata_s[i][7:0];
            end
        end
    end

    // Watchdog increment and hang detection; a trap in the same cycle wins.
    always_comb begin
        wd_inc   = wd + 1'b1;
        hang_set = run && (acc == '0) && (wd_inc == WD_W'(TIMEOUT)) && !trap_hit;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state: leave RUN on trap or hang; FROZEN only exits through reset
    always_comb begin
        state_nxt = state;
        if (state == RUN && (trap_hit || hang_set))
            state_nxt = FROZEN;
    end

    // State outputs
    always_comb begin
        run = (state == RUN);
    end

    // Commit registers, one instance per slot
    genvar g;
    generate
        for (g = 0; g < NCOMMIT; g++) begin : g_slot
            difftest_commit_slot #(.XLEN(XLEN)) u_slot (
                .clock     (clock),
                .reset     (reset),
                .accept    (acc[g]),
                .pc        (pc_s[g]),
                .inst      (inst_s[g]),
                .rf_we     (wb_rf_we[g]),
                .wnum      (wnum_s[g]),
                .wdata     (wdata_s[g]),
                .cmt_valid (cmt_valid[g]),
                .cmt_pc    (cpc_s[g]),
                .cmt_inst  (cinst_s[g]),
                .cmt_wen   (cmt_wen[g]),
                .cmt_wdest (cwdest_s[g]),
                .cmt_wdata (cwdata_s[g])
            );
        end
    endgenerate

    assign cmt_pc    = cpc_s;
    assign cmt_inst  = cinst_s;
    assign cmt_wdest = cwdest_s;
    assign cmt_wdata = cwdata_s;
    assign arch_regs = rf;

    // Shadow RF: slots applied oldest first so the younger write lands last; x0 untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            rf <= '0;
        end else begin
            for (int i = 0; i < NCOMMIT; i++)
                if (acc[i] && wb_rf_we[i] && wnum_s[i] != 5'd0)
                    rf[wnum_s[i]] <= wdata_s[i];
        end
    end

    // Counters, watchdog and sticky trap/hang; all hold while frozen
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            wd        <= '0;
            trap      <= 1'b0;
            trap_code <= '0;
            trap_pc   <= '0;
            hang      <= 1'b0;
        end else if (run) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            instr_cnt <= instr_cnt + 64'(n_acc);
            wd        <= (acc != '0) ? '0 : wd_inc;
            if (trap_hit) begin
                trap      <= 1'b1;
                trap_code <= trap_code_nxt;
                trap_pc   <= trap_pc_nxt;
            end
            if (hang_set)
                hang <= 1'b1;
        end
    end
endmodule

// File: tb/tb_difftest_commit_unit.sv
// Scoreboard bench for difftest_commit_unit: the stimulus process runs a
// behavioural model and queues the expected post-edge state; the monitor pops
// and compares after every clock edge.
module tb_difftest_commit_unit;
    localparam int TO = 40;

    logic           clock, reset;
    logic [1:0]     wb_valid, wb_rf_we;
    logic [127:0]   wb_pc, wb_rf_wdata;
    logic [63:0]    wb_inst;
    logic [9:0]     wb_rf_wnum;
    logic [1:0]     cmt_valid, cmt_wen;
    logic [127:0]   cmt_pc, cmt_wdata;
    logic [63:0]    cmt_inst;
    logic [15:0]    cmt_wdest;
    logic [2047:0]  arch_regs;
    logic           trap, hang;
    logic [7:0]     trap_code;
    logic [63:0]    trap_pc, cycle_cnt, instr_cnt;

    difftest_commit_unit #(.NCOMMIT(2), .XLEN(64), .TIMEOUT(TO), .TRAP_OP(7'h6b)) dut (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_rf_we(wb_rf_we), .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen),
        .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .arch_regs(arch_regs), .trap(trap),
        .trap_code(trap_code), .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .hang(hang)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]    cv;
        logic [63:0]   cpc [2];
        logic [31:0]   cinst [2];
        logic [1:0]    cwen;
        logic [7:0]    cwdest [2];
        logic [63:0]   cwd [2];
        logic [63:0]   regs [32];
        logic          trap;
        logic [7:0]    tcode;
        logic [63:0]   tpc, cyc, icnt;
        logic          hang;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   m_wd;
    bit   m_frozen;
    int   total = 0, bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference model: one clock edge of architectural behaviour
    task automatic model(input logic rst, input logic [1:0] v, input logic [63:0] pc [2],
                         input logic [31:0] in [2], input logic [1:0] we,
                         input logic [4:0] wn [2], input logic [63:0] wd [2]);
        bit any, stop;
        if (rst) begin
            m.cv = 0; m.cwen = 0; m.trap = 0; m.tcode = 0; m.tpc = 0;
            m.cyc = 0; m.icnt = 0; m.hang = 0;
            for (int i = 0; i < 2; i++) begin
                m.cpc[i] = 0; m.cinst[i] = 0; m.cwdest[i] = 0; m.cwd[i] = 0;
            end
            for (int r = 0; r < 32; r++) m.regs[r] = 0;
            m_wd = 0; m_frozen = 0;
        end else if (m_frozen) begin
            m.cv = 0;
        end else begin
            any = 0; stop = 0;
            for (int i = 0; i < 2; i++) begin
                if (v[i] && !stop) begin
                    any = 1;
                    m.cv[i] = 1;
                    m.cpc[i] = pc[i]; m.cinst[i] = in[i];
                    m.cwen[i] = we[i] && wn[i] != 0;
                    m.cwdest[i] = {3'b000, wn[i]};
                    m.cwd[i] = wd[i];
                    m.icnt++;
                    if (in[i][6:0] == 7'h6b) begin
                        m.trap = 1; m.tpc = pc[i]; m.tcode = m.regs[10][7:0]; stop = 1;
                    end
                    if (we[i] && wn[i] != 0) m.regs[wn[i]] = wd[i];
                end else begin
                    m.cv[i] = 0;
                end
            end
            m.cyc++;
            m_wd = any ? 0 : m_wd + 1;
            if (!m.trap && m_wd == TO) m.hang = 1;
            m_frozen = m.trap || m.hang;
        end
    endtask

    task automatic cyc(input logic rst, input logic [1:0] v, input logic [63:0] pc0, pc1,
                       input logic [31:0] i0, i1, input logic [1:0] we,
                       input logic [4:0] n0, n1, input logic [63:0] d0, d1);
        logic [63:0] pc [2];
        logic [31:0] in [2];
        logic [4:0]  wn [2];
        logic [63:0] wd [2];
        @(negedge clock);
        reset = rst; wb_valid = v; wb_pc = {pc1, pc0}; wb_inst = {i1, i0};
        wb_rf_we = we; wb_rf_wnum = {n1, n0}; wb_rf_wdata = {d1, d0};
        pc[0] = pc0; pc[1] = pc1; in[0] = i0; in[1] = i1;
        wn[0] = n0; wn[1] = n1; wd[0] = d0; wd[1] = d1;
        model(rst, v, pc, in, we, wn, wd);
        q.push_back(m);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clock); #2;
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cmt_valid", 64'(cmt_valid), 64'(e.cv));
                for (int i = 0; i < 2; i++) begin
                    if (cmt_valid[i]) begin
                        check($sformatf("cmt_pc%0d", i), cmt_pc[i*64 +: 64], e.cpc[i]);
                        check($sformatf("cmt_inst%0d", i), 64'(cmt_inst[i*32 +: 32]), 64'(e.cinst[i]));
                        check($sformatf("cmt_wen%0d", i), 64'(cmt_wen[i]), 64'(e.cwen[i]));
                        check($sformatf("cmt_wdest%0d", i), 64'(cmt_wdest[i*8 +: 8]), 64'(e.cwdest[i]));
                        check($sformatf("cmt_wdata%0d", i), cmt_wdata[i*64 +: 64], e.cwd[i]);
                    end
                end
                total++;
                begin
                    int badr;
                    badr = -1;
                    for (int r = 31; r >= 0; r--)
                        if (arch_regs[r*64 +: 64] !== e.regs[r]) badr = r;
                    if (badr >= 0) begin
                        bad++;
                        $display("FAIL arch_regs x%0d act=%h exp=%h", badr,
                                 arch_regs[badr*64 +: 64], e.regs[badr]);
                    end
                end
                check("trap", 64'(trap), 64'(e.trap));
                check("trap_code", 64'(trap_code), 64'(e.tcode));
                check("trap_pc", trap_pc, e.tpc);
                check("cycle_cnt", cycle_cnt, e.cyc);
                check("instr_cnt", instr_cnt, e.icnt);
                check("hang", 64'(hang), 64'(e.hang));
            end
        end
    end

    // Safety net against a stuck run
    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [31:0] i0, i1;
        reset = 1; wb_valid = 0; wb_pc = 0; wb_inst = 0;
        wb_rf_we = 0; wb_rf_wnum = 0; wb_rf_wdata = 0;

        do_reset(); do_reset();
        settle();
        check("rst_cmt_valid", 64'(cmt_valid), 64'd0);
        check("rst_cycle_cnt", cycle_cnt, 64'd0);

        // addi x5, x0, 7
        cyc(0, 2'b01, 64'h80000000, 0, 32'h00700293, 0, 2'b01, 5, 0, 64'd7, 0);
        settle();
        check("t1_cmt_valid", 64'(cmt_valid), 64'd1);
        check("t1_wdest0", 64'(cmt_wdest[7:0]), 64'd5);
        check("t1_x5", arch_regs[5*64 +: 64], 64'd7);
        check("t1_instr_cnt", instr_cnt, 64'd1);

        // both slots write x6; the younger one wins
        cyc(0, 2'b11, 64'h80000004, 64'h80000008, 32'h00100313, 32'h00200313, 2'b11, 6, 6, 64'd1, 64'd2);
        settle();
        check("t2_x6", arch_regs[6*64 +: 64], 64'd2);
        check("t2_cmt_wen", 64'(cmt_wen), 64'd3);
        check("t2_instr_cnt", instr_cnt, 64'd3);

        // x10 written by slot0, trap in slot1 sees it
        cyc(0, 2'b11, 64'h8000000c, 64'h80000010, 32'h02a00513, 32'h0000006b, 2'b01, 10, 0, 64'h2a, 0);
        settle();
        check("t3_trap", 64'(trap), 64'd1);
        check("t3_trap_code", 64'(trap_code), 64'h2a);
        check("t3_trap_pc", trap_pc, 64'h80000010);
        cyc(0, 2'b11, 64'h80000014, 64'h80000018, 32'h00100393, 32'h00100393, 2'b11, 7, 7, 64'd5, 64'd5);
        idle(3);
        settle();
        check("t3_frozen_instr", instr_cnt, 64'd5);
        check("t3_frozen_cycle", cycle_cnt, 64'd3);
        check("t3_frozen_valid", 64'(cmt_valid), 64'd0);

        // trap in slot0 drops the write in slot1
        do_reset();
        cyc(0, 2'b11, 64'h80000000, 64'h80000004, 32'h0000006b, 32'h00900393, 2'b10, 0, 7, 0, 64'd9);
        settle();
        check("t4_cmt_valid", 64'(cmt_valid), 64'd1);
        check("t4_x7", arch_regs[7*64 +: 64], 64'd0);
        check("t4_instr_cnt", instr_cnt, 64'd1);

        // reset out of trap, then a normal commit
        do_reset();
        settle();
        check("t6_trap", 64'(trap), 64'd0);
        check("t6_instr_cnt", instr_cnt, 64'd0);
        cyc(0, 2'b01, 64'h80000100, 0, 32'h00300293, 0, 2'b01, 5, 0, 64'd3, 0);
        settle();
        check("t6_cmt_valid", 64'(cmt_valid), 64'd1);
        check("t6_x5", arch_regs[5*64 +: 64], 64'd3);

        // x0 write suppressed, then idle into the watchdog
        do_reset();
        cyc(0, 2'b01, 64'h80000000, 0, 32'h0ff00013, 0, 2'b01, 0, 0, 64'hffff, 0);
        settle();
        check("t5_cmt_wen", 64'(cmt_wen), 64'd0);
        check("t5_x0", arch_regs[63:0], 64'd0);
        idle(TO - 1);
        settle();
        check("t5_no_hang_yet", 64'(hang), 64'd0);
        idle(4);
        settle();
        check("t5_hang", 64'(hang), 64'd1);
        check("t5_cycle_stop", cycle_cnt, 64'(1 + TO));

        // randomized traffic; reset whenever the model has frozen
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (m_frozen && $urandom_range(0, 2) == 0) begin
                do_reset();
            end else begin
                i0 = $urandom; i1 = $urandom;
                if (i0[6:0] == 7'h6b) i0[0] = 1'b0;
                if (i1[6:0] == 7'h6b) i1[0] = 1'b0;
                if ($urandom_range(0, 39) == 0) i0[6:0] = 7'h6b;
                if ($urandom_range(0, 39) == 0) i1[6:0] = 7'h6b;
                cyc(0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, i0, i1,
                    2'($urandom), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                    {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        settle();
        settle();
        check("queue_drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
